// File: rtl/pixel_pack_pkg.sv
// pixel_pack_pkg: shared definitions for the pixel packer.
//   - GenICam pixel-format codes understood by the packer
//   - 6-bit decode keys {fmt[20], fmt[19], fmt[3:0]} that select 8-bit packing
//   - FSM state encoding and per-mode last-slot indices
package pixel_pack_pkg;

    // GenICam pixel-format codes
    localparam logic [31:0] MONO8     = 32'h0108_0001;
    localparam logic [31:0] MONO10    = 32'h0110_0003;
    localparam logic [31:0] BAYERGR8  = 32'h0108_0008;
    localparam logic [31:0] BAYERGR10 = 32'h0110_000C;

    // Decode keys that select 8-bit packing; every other key packs 10-bit
    localparam logic [5:0] FMT_KEY_MONO8    = 6'b01_0001;
    localparam logic [5:0] FMT_KEY_BAYERGR8 = 6'b01_1000;

    // Index of the final slot in a word for each packing mode
    localparam logic [1:0] LAST_SLOT_8BIT  = 2'd3;
    localparam logic [1:0] LAST_SLOT_10BIT = 2'd1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,  // fval low
        StFrame = 2'd1,  // fval high, between lines
        StLine  = 2'd2,  // collecting pixels
        StFlush = 2'd3   // emitting a zero-filled partial word
    } pack_state_e;

endpackage

// File: rtl/pix_fmt_decode.sv
// pix_fmt_decode: combinational GenICam pixel-format to packing-mode decode.
// Ports:
//   iv_pixel_format  in   REG_WD  pixel-format register (REG_WD >= 22)
//   o_mode8          out  1       1 = pack 4 x 8-bit, 0 = pack 2 x 10-bit
module pix_fmt_decode
    import pixel_pack_pkg::*;
#(
    parameter int REG_WD = 32
) (
    input  logic [REG_WD-1:0] iv_pixel_format,
    output logic              o_mode8
);

    logic [5:0] fmt_key;
    logic       unused_fmt;

    assign fmt_key = {iv_pixel_format[20], iv_pixel_format[19], iv_pixel_format[3:0]};
    assign o_mode8 = (fmt_key == FMT_KEY_MONO8) || (fmt_key == FMT_KEY_BAYERGR8);

    // Remaining format bits play no part in the decision
    assign unused_fmt = ^{iv_pixel_format[REG_WD-1:21], iv_pixel_format[18:4]};

endmodule

// File: rtl/pixel_pack.sv
// pixel_pack: packs a line-structured pixel stream into 32-bit words.
//   8-bit mode : 4 pixels per word (top 8 bits of each pixel, first pixel in LSB byte)
//   10-bit mode: 2 pixels per word, word = {6'b0, p1, 6'b0, p0}
//   A line ending mid-word emits a zero-filled partial word one cycle later.
//   Packing mode is latched at the rising edge of i_fval and held for the frame.
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   iv_pixel_format    GenICam pixel format, sampled at frame start
//   i_fval, i_lval     frame / line valid; a pixel is taken when both are high
//   iv_pix_data        input pixel
//   o_fval             i_fval delayed by two cycles
//   o_lval             one-cycle strobe per packed word
//   ov_pix_data        packed word; holds its value while o_lval is low
// Optional build macro PIXEL_PACK_STAT_EN adds:
//   ov_line_cnt        lines in the last completed frame (updated at fval fall)
//   o_partial_err      set for the frame when any partial word is flushed
module pixel_pack
    import pixel_pack_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 10,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int REG_WD         = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_WD-1:0]         iv_pixel_format,
    input  logic                      i_fval,
    input  logic                      i_lval,
    input  logic [DATA_IN_WIDTH-1:0]  iv_pix_data,
    output logic                      o_fval,
    output logic                      o_lval,
`ifdef PIXEL_PACK_STAT_EN
    output logic [15:0]               ov_line_cnt,
    output logic                      o_partial_err,
`endif
    output logic [DATA_OUT_WIDTH-1:0] ov_pix_data
);

    pack_state_e state_q, state_d;

    logic                      fval_prev_q;
    logic [1:0]                fval_dly_q;
    logic                      mode8_q, mode8_d, mode8_dec, mode8_cur;
    logic [1:0]                cnt_q, cnt_d;
    logic [DATA_OUT_WIDTH-1:0] acc_q, acc_d;
    logic                      lval_q, lval_d;
    logic [DATA_OUT_WIDTH-1:0] data_q, data_d;

    logic                      frame_start;
    logic                      active;
    logic                      cap;
    logic                      in_line;
    logic                      flush;
    logic [1:0]                slot;
    logic [1:0]                last_slot;
    logic [7:0]                pix8;
    logic [9:0]                pix10;
    logic [DATA_OUT_WIDTH-1:0] placed;
    logic [DATA_OUT_WIDTH-1:0] acc_next;

    pix_fmt_decode #(
        .REG_WD (REG_WD)
    ) u_fmt_decode (
        .iv_pixel_format (iv_pixel_format),
        .o_mode8         (mode8_dec)
    );

    assign pix8 = iv_pix_data[DATA_IN_WIDTH-1:DATA_IN_WIDTH-8];

    // 10-bit mode keeps the 10 MSBs; narrower inputs are left-justified
    if (DATA_IN_WIDTH >= 10) begin : g_pix10_wide
        assign pix10 = iv_pix_data[DATA_IN_WIDTH-1:DATA_IN_WIDTH-10];
    end else begin : g_pix10_narrow
        assign pix10 = {iv_pix_data, {(10 - DATA_IN_WIDTH){1'b0}}};
    end

    // fval_prev_q resets high so a frame already running at reset release is
    // skipped; packing resumes only at a genuine fval rising edge.
    assign frame_start = i_fval & ~fval_prev_q;
    assign active      = (state_q != StIdle) | frame_start;
    assign cap         = active & i_fval & i_lval;
    assign in_line     = (state_q == StLine);
    assign mode8_cur   = frame_start ? mode8_dec : mode8_q;
    assign mode8_d     = frame_start ? mode8_dec : mode8_q;

    // The first pixel of every line lands in slot 0
    assign slot      = in_line ? cnt_q : 2'd0;
    assign last_slot = mode8_cur ? LAST_SLOT_8BIT : LAST_SLOT_10BIT;
    assign placed    = mode8_cur ? (DATA_OUT_WIDTH'(pix8) << {slot, 3'b000})
                                 : (DATA_OUT_WIDTH'(pix10) << {slot, 4'b0000});
    assign acc_next  = ((slot == 2'd0) ? '0 : acc_q) | placed;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = i_lval ? StLine : StFrame;
                end
            end
            StFrame: begin
                if (!i_fval) begin
                    state_d = StIdle;
                end else if (i_lval) begin
                    state_d = StLine;
                end
            end
            StLine: begin
                // fval falling with lval still high is a line end as well
                if (!cap) begin
                    if (cnt_q != 2'd0) begin
                        state_d = StFlush;
                    end else begin
                        state_d = i_fval ? StFrame : StIdle;
                    end
                end
            end
            StFlush: begin
                if (!i_fval) begin
                    state_d = StIdle;
                end else if (i_lval) begin
                    state_d = StLine;
                end else begin
                    state_d = StFrame;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Packing datapath
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        lval_d = 1'b0;
        data_d = data_q;
        flush  = 1'b0;
        if (cap) begin
            if (slot == last_slot) begin
                lval_d = 1'b1;
                data_d = acc_next;
                cnt_d  = 2'd0;
                acc_d  = '0;
            end else begin
                cnt_d = slot + 2'd1;
                acc_d = acc_next;
            end
        end else if (in_line) begin
            // Unused upper slots are already zero in the accumulator
            if (cnt_q != 2'd0) begin
                lval_d = 1'b1;
                data_d = acc_q;
                flush  = 1'b1;
            end
            cnt_d = 2'd0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fval_prev_q <= 1'b1;
            fval_dly_q  <= 2'b00;
            mode8_q     <= 1'b0;
            cnt_q       <= 2'd0;
            acc_q       <= '0;
            lval_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            fval_prev_q <= i_fval;
            fval_dly_q  <= {fval_dly_q[0], i_fval};
            mode8_q     <= mode8_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lval_q      <= lval_d;
            data_q      <= data_d;
        end
    end

    assign o_fval      = fval_dly_q[1];
    assign o_lval      = lval_q;
    assign ov_pix_data = data_q;

`ifdef PIXEL_PACK_STAT_EN
    logic        line_start;
    logic        fval_fall;
    logic [15:0] lines_q;
    logic [15:0] line_cnt_q;
    logic        partial_err_q;

    assign line_start = cap & ~in_line;
    assign fval_fall  = ~i_fval & fval_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lines_q       <= 16'd0;
            line_cnt_q    <= 16'd0;
            partial_err_q <= 1'b0;
        end else begin
            lines_q <= (frame_start ? 16'd0 : lines_q) + 16'(line_start);
            if (fval_fall) begin
                line_cnt_q <= lines_q;
            end
            // Flushes after fval falls still belong to the frame just ended
            partial_err_q <= (partial_err_q & ~frame_start) | flush;
        end
    end

    assign ov_line_cnt   = line_cnt_q;
    assign o_partial_err = partial_err_q;
`else
    logic unused_flush;
    assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_pixel_pack.sv
// tb_pixel_pack: directed self-checking bench for pixel_pack.
// Inputs change 1 ns after each rising edge; words are collected on the
// falling edge together with the number of the edge that produced them.
module tb_pixel_pack;

    localparam logic [31:0] FMT_MONO8     = 32'h0108_0001;
    localparam logic [31:0] FMT_MONO10    = 32'h0110_0003;
    localparam logic [31:0] FMT_BAYERGR8  = 32'h0108_0008;
    localparam logic [31:0] FMT_BAYERGR10 = 32'h0110_000C;

    logic        clk;
    logic        reset_n;
    logic [31:0] iv_pixel_format;
    logic        i_fval;
    logic        i_lval;
    logic [9:0]  iv_pix_data;
    logic        o_fval;
    logic        o_lval;
    logic [31:0] ov_pix_data;
`ifdef PIXEL_PACK_STAT_EN
    logic [15:0] ov_line_cnt;
    logic        o_partial_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] got_d[$];
    int          got_c[$];
    logic [31:0] exp_d[$];
    int          exp_c[$];

    pixel_pack #(
        .DATA_IN_WIDTH  (10),
        .DATA_OUT_WIDTH (32),
        .REG_WD         (32)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .iv_pixel_format (iv_pixel_format),
        .i_fval          (i_fval),
        .i_lval          (i_lval),
        .iv_pix_data     (iv_pix_data),
        .o_fval          (o_fval),
        .o_lval          (o_lval),
`ifdef PIXEL_PACK_STAT_EN
        .ov_line_cnt     (ov_line_cnt),
        .o_partial_err   (o_partial_err),
`endif
        .ov_pix_data     (ov_pix_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Collect every emitted word; each must lie inside o_fval
    always @(negedge clk) begin
        if (o_lval === 1'b1) begin
            got_d.push_back(ov_pix_data);
            got_c.push_back(cyc);
            check_eq("word_inside_fval", {31'b0, o_fval}, 32'd1);
        end
    end

    task automatic drv(input logic fv, input logic lv, input logic [9:0] px);
        i_fval      = fv;
        i_lval      = lv;
        iv_pix_data = px;
        @(posedge clk);
        #1;
    endtask

    // Expected word, due on the edge just taken
    task automatic exp_word(input logic [31:0] w);
        exp_d.push_back(w);
        exp_c.push_back(cyc);
    endtask

    task automatic start_frame(input logic [31:0] fmt);
        iv_pixel_format = fmt;
        drv(1'b1, 1'b0, 10'h0);
    endtask

    task automatic end_frame();
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 10'h0);
    endtask

    task automatic compare_words(input string tag);
        int n;
        check_eq({tag, "_count"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_data"}, got_d[i], exp_d[i]);
            check_eq({tag, "_cycle"}, got_c[i], exp_c[i]);
        end
        got_d.delete();
        got_c.delete();
        exp_d.delete();
        exp_c.delete();
    endtask

    // One line of random pixels followed by a one-cycle lval gap
    task automatic run_line(input int n, input bit m8);
        logic [31:0] w;
        logic [9:0]  px;
        int          k;
        w = 32'h0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            px = 10'($urandom_range(1023, 0));
            drv(1'b1, 1'b1, px);
            if (m8) w = w | (32'(px[9:2]) << (8 * k));
            else    w = w | (32'(px) << (16 * k));
            k++;
            if (k == (m8 ? 4 : 2)) begin
                exp_word(w);
                w = 32'h0;
                k = 0;
            end
        end
        drv(1'b1, 1'b0, 10'h0);
        if (k != 0) exp_word(w);
    endtask

    initial begin
        int lens[8];
        int total;
        lens = '{1, 2, 3, 4, 5, 7, 8, 9};

        reset_n         = 1'b0;
        iv_pixel_format = FMT_MONO8;
        i_fval          = 1'b0;
        i_lval          = 1'b0;
        iv_pix_data     = 10'h0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_fval", {31'b0, o_fval}, 32'd0);
        check_eq("rst_lval", {31'b0, o_lval}, 32'd0);
        check_eq("rst_data", ov_pix_data, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 10'h0);

        // Mono8, 8 pixels -> two full words
        start_frame(FMT_MONO8);
        check_eq("ofval_delay1", {31'b0, o_fval}, 32'd0);
        drv(1'b1, 1'b0, 10'h0);
        check_eq("ofval_delay2", {31'b0, o_fval}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 1'b1, 10'((i + 1) * 4));
            if (i == 3) begin
                exp_word(32'h0403_0201);
                check_eq("m8_strobe", {31'b0, o_lval}, 32'd1);
                check_eq("m8_word0", ov_pix_data, 32'h0403_0201);
            end
            if (i == 4) begin
                check_eq("m8_strobe_low", {31'b0, o_lval}, 32'd0);
                check_eq("m8_hold", ov_pix_data, 32'h0403_0201);
            end
            if (i == 7) exp_word(32'h0807_0605);
        end
        drv(1'b1, 1'b0, 10'h0);
        check_eq("m8_no_flush", {31'b0, o_lval}, 32'd0);
        end_frame();
        compare_words("mono8");

        // Mono10 with a partial group at line end
        start_frame(FMT_MONO10);
        drv(1'b1, 1'b1, 10'h3FF);
        drv(1'b1, 1'b1, 10'h001);
        exp_word(32'h0001_03FF);
        drv(1'b1, 1'b1, 10'h155);
        drv(1'b1, 1'b0, 10'h0);
        exp_word(32'h0000_0155);
        check_eq("m10_flush_strobe", {31'b0, o_lval}, 32'd1);
        check_eq("m10_flush_data", ov_pix_data, 32'h0000_0155);
        end_frame();
        compare_words("mono10");

        // BayerGR8, 6 pixels -> full word + flush word
        start_frame(FMT_BAYERGR8);
        drv(1'b1, 1'b1, 10'h044);
        drv(1'b1, 1'b1, 10'h088);
        drv(1'b1, 1'b1, 10'h0CC);
        drv(1'b1, 1'b1, 10'h110);
        exp_word(32'h4433_2211);
        drv(1'b1, 1'b1, 10'h154);
        drv(1'b1, 1'b1, 10'h198);
        drv(1'b1, 1'b0, 10'h0);
        exp_word(32'h0000_6655);
        end_frame();
        compare_words("bayer8");
`ifdef PIXEL_PACK_STAT_EN
        check_eq("stat_partial_err", {31'b0, o_partial_err}, 32'd1);
        check_eq("stat_line_cnt", {16'b0, ov_line_cnt}, 32'd1);
`endif

        // Format switched mid-frame: stays 8-bit until the next frame
        start_frame(FMT_MONO8);
        drv(1'b1, 1'b1, 10'h100);
        drv(1'b1, 1'b1, 10'h200);
        drv(1'b1, 1'b1, 10'h300);
        drv(1'b1, 1'b1, 10'h3FC);
        exp_word(32'hFFC0_8040);
        drv(1'b1, 1'b0, 10'h0);
        iv_pixel_format = FMT_MONO10;
        drv(1'b1, 1'b0, 10'h0);
        drv(1'b1, 1'b1, 10'h100);
        drv(1'b1, 1'b1, 10'h200);
        drv(1'b1, 1'b1, 10'h300);
        drv(1'b1, 1'b1, 10'h3FC);
        exp_word(32'hFFC0_8040);
        drv(1'b1, 1'b0, 10'h0);
        end_frame();
        start_frame(FMT_MONO10);
        drv(1'b1, 1'b1, 10'h100);
        drv(1'b1, 1'b1, 10'h200);
        exp_word(32'h0200_0100);
        drv(1'b1, 1'b1, 10'h300);
        drv(1'b1, 1'b1, 10'h3FC);
        exp_word(32'h03FC_0300);
        drv(1'b1, 1'b0, 10'h0);
        end_frame();
        compare_words("fmt_switch");

        // fval falls while lval is high -> flush, still inside o_fval
        start_frame(FMT_MONO10);
        drv(1'b1, 1'b1, 10'h001);
        drv(1'b1, 1'b1, 10'h002);
        exp_word(32'h0002_0001);
        drv(1'b1, 1'b1, 10'h003);
        drv(1'b0, 1'b0, 10'h0);
        exp_word(32'h0000_0003);
        check_eq("fall_flush_fval", {31'b0, o_fval}, 32'd1);
        end_frame();
        compare_words("fval_fall");

        // Reset mid-line after 3 Mono8 pixels
        start_frame(FMT_MONO8);
        drv(1'b1, 1'b1, 10'h004);
        drv(1'b1, 1'b1, 10'h008);
        drv(1'b1, 1'b1, 10'h00C);
        i_lval = 1'b1;
        iv_pix_data = 10'h010;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_fval", {31'b0, o_fval}, 32'd0);
        check_eq("mid_rst_lval", {31'b0, o_lval}, 32'd0);
        check_eq("mid_rst_data", ov_pix_data, 32'h0);
        @(posedge clk);
        #1;
        drv(1'b1, 1'b1, 10'h014);
        reset_n = 1'b1;
        // Frame still running at release must be ignored
        for (int i = 0; i < 6; i++) drv(1'b1, 1'b1, 10'(8 * i + 8));
        // lval without fval must be ignored
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 10'h3FF);
        drv(1'b0, 1'b0, 10'h0);
        drv(1'b0, 1'b0, 10'h0);
        compare_words("after_rst_quiet");
        start_frame(FMT_MONO8);
        drv(1'b1, 1'b1, 10'h010);
        drv(1'b1, 1'b1, 10'h020);
        drv(1'b1, 1'b1, 10'h030);
        drv(1'b1, 1'b1, 10'h040);
        exp_word(32'h100C_0804);
        drv(1'b1, 1'b0, 10'h0);
        end_frame();
        compare_words("after_rst_frame");

        // Back-to-back lines, 1-cycle gaps, both modes
        total = 0;
        start_frame(FMT_MONO8);
        for (int i = 0; i < 8; i++) begin
            run_line(lens[i], 1'b1);
            total += (lens[i] + 3) / 4;
        end
        end_frame();
        check_eq("b2b_m8_words", got_d.size(), total);
        compare_words("b2b_m8");
        total = 0;
        start_frame(FMT_BAYERGR10);
        for (int i = 0; i < 8; i++) begin
            run_line(lens[i], 1'b0);
            total += (lens[i] + 1) / 2;
        end
        end_frame();
        check_eq("b2b_m10_words", got_d.size(), total);
        compare_words("b2b_m10");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_pack.md
PIXEL_PACK -- requirements
Module: pixel_pack

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 10, input pixel width; SHALL be >= 8.
REQ-002 Parameter DATA_OUT_WIDTH, default 32, packed word width; SHALL be fixed at 32.
REQ-003 Parameter REG_WD, default 32, width of the pixel-format register.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 iv_pixel_format  input  REG_WD  GenICam pixel format: 0x01080001 Mono8, 0x01100003 Mono10, 0x01080008 BayerGR8, 0x0110000C BayerGR10.
REQ-007 i_fval  input  1  input frame valid.
REQ-008 i_lval  input  1  input line valid; a pixel SHALL be taken on each cycle with i_fval=1 and i_lval=1.
REQ-009 iv_pix_data  input  DATA_IN_WIDTH  input pixel.
REQ-010 o_fval  output  1  output frame valid.
REQ-011 o_lval  output  1  packed-word strobe; high for exactly one cycle per word.
REQ-012 ov_pix_data  output  32  packed word, valid only when o_lval=1.

Function
REQ-013 Format decode on {fmt[20],fmt[19],fmt[3:0]}: 6'b010001 or 6'b011000 -> 8-bit mode; all other values -> 10-bit mode.
REQ-014 Mode SHALL be latched on the i_fval rising edge and held for the whole frame; format changes mid-frame SHALL be ignored.
REQ-015 8-bit mode: 4 pixels/word, pixel n bits [DATA_IN_WIDTH-1:DATA_IN_WIDTH-8] placed at word bits [8n+7:8n]; the first pixel goes in the LSB byte.
REQ-016 10-bit mode: 2 pixels/word, word = {6'b0,p1,6'b0,p0}.
REQ-017 Full word: o_lval=1 and ov_pix_data valid 1 cycle after the clock edge that captures the last pixel of the group.
REQ-018 Line end with a partial group (lval falls while the slot counter is nonzero): the remaining slots SHALL be zero-filled and the word emitted 1 cycle after the first cycle with lval=0.
REQ-019 The slot counter SHALL be cleared at every line start, so words never straddle lines.
REQ-020 FSM states: IDLE (fval=0); FRAME (fval=1, lval=0); LINE (collecting); FLUSH (one cycle, emitting a partial word).
REQ-021 FSM transitions: IDLE->FRAME on fval rise; FRAME->LINE on lval rise; LINE->FRAME on lval fall with counter=0; LINE->FLUSH on lval fall with counter!=0; FLUSH->FRAME or IDLE; any state->IDLE on fval=0, after any pending flush completes.
REQ-022 o_fval SHALL be i_fval delayed by 2 cycles, so every word, including a flush word, lies inside o_fval.
REQ-023 lval=1 while fval=0 SHALL be ignored, with no capture and no output.
REQ-024 fval falling while lval=1: treated as a line end (flush rule applies), then IDLE.
REQ-025 ov_pix_data SHALL hold its last value when o_lval=0.

Reset
REQ-026 On reset_n=0, immediately: FSM=IDLE, slot counter=0, mode=10-bit, o_fval=0, o_lval=0, ov_pix_data=0.
REQ-027 Reset asserted mid-line SHALL discard the partial group; after release, output SHALL begin only at the next i_fval rising edge.

Configuration
REQ-028 Macro PIXEL_PACK_STAT_EN defined: adds outputs ov_line_cnt[15:0] (lines in the last frame, updated at fval fall) and o_partial_err (sticky for the frame; set on any flush); both reset to 0.
REQ-029 Macro PIXEL_PACK_STAT_EN undefined: those ports and their logic SHALL be absent; packing behaviour SHALL be identical in both builds.

Structure
REQ-030 Shared package pixel_pack_pkg: pixel-format constants (MONO8, MONO10, BAYERGR8, BAYERGR10), 6-bit decode patterns, FSM state encodings.
REQ-031 One sub-module, pix_fmt_decode: combinational format-to-mode decode, reusable by checkers.

Verification
REQ-032 Mono8, 1 line of 8 pixels 0x004,0x008,...,0x020 (DATA_IN_WIDTH=10) -> 2 words 0x04030201, 0x08070605; each one cycle after its 4th pixel.
REQ-033 Mono10, pixels 0x3FF,0x001,0x155 -> words 0x000103FF, then flush 0x00000155 one cycle after lval falls.
REQ-034 BayerGR8, 6-pixel line -> 1 full word plus 1 flush word with upper 2 bytes 0; with PIXEL_PACK_STAT_EN, o_partial_err=1.
REQ-035 Format switched Mono8->Mono10 mid-frame -> packing stays 8-bit until the next frame; 10-bit from the next fval rise.
REQ-036 reset_n pulsed low after 3 Mono8 pixels -> all outputs 0 immediately; no word emitted for those pixels; the next frame packs correctly.
REQ-037 Bench SHALL run back-to-back lines with 1-cycle lval gaps, checked against a reference model -> zero mismatches; o_lval count = ceil(pixels/4) per line.
